memory_access_unit_pipelined: RTL and testbench

Pipelined successor of the single-shot memory access unit. Accepts up to one LOAD/STORE instruction per cycle, keeps up to LATENCY instructions in flight and completes them in order against an internal word-addressed scratch memory. Sits between the instruction issue stage and the register file: it drives register read selects, samples register data at acceptance, and emits register write-back.

---
 rtl/memory_access_unit_pipelined.sv | 137 +++++++++++++
 tb/tb_memory_access_unit_pipelined.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit_pipelined.sv
// Pipelined LOAD/STORE unit: fixed-latency in-order pipeline over a scratch memory, with a register scoreboard.
// Optional build macro MAU_PERF_COUNTERS_EN adds completed load/store and stall-cycle counters.
module memory_access_unit_pipelined #(
  parameter  int LATENCY            = 4,
  parameter  int DATA_WIDTH         = 32,
  parameter  int INSTRUCTION_LENGTH = 32,
  parameter  int OPCODE_LENGTH      = 8,
  parameter  int NUM_REGISTERS      = 4,
  parameter  int MEM_DEPTH          = 16,
  localparam int REG_SEL_W          = $clog2(NUM_REGISTERS),
  localparam int MEM_ADDR_W         = $clog2(MEM_DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [INSTRUCTION_LENGTH-1:0] instruction_i,
  input  logic                          instruction_valid_i,
  output logic                          ready_o,
  output logic [2*REG_SEL_W-1:0]        register_select_o,
  input  logic [2*DATA_WIDTH-1:0]       register_data_i,
  output logic [REG_SEL_W-1:0]          write_register_select_o,
  output logic [DATA_WIDTH-1:0]         register_data_o,
  output logic                          register_write_o,
  output logic                          instruction_done_o,
  output logic                          error_o
`ifdef MAU_PERF_COUNTERS_EN
  ,
  output logic [31:0]                   load_count_o,
  output logic [31:0]                   store_count_o,
  output logic [31:0]                   stall_count_o
`endif
);

  localparam logic [OPCODE_LENGTH-1:0] OPC_LOAD  = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OPC_STORE = OPCODE_LENGTH'(2);

  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_LOAD, OP_STORE, OP_ILLEGAL} op_e;

  typedef struct packed {
    op_e                   op;
    logic [REG_SEL_W-1:0]  reg_sel;
    logic [MEM_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  logic [OPCODE_LENGTH-1:0] opcode;
  logic [REG_SEL_W-1:0]     src_sel;
  logic [REG_SEL_W-1:0]     dst_sel;
  logic [NUM_REGISTERS-1:0] pending;
  logic [NUM_REGISTERS-1:0] wb_clear;
  logic [NUM_REGISTERS-1:0] busy;
  logic [NUM_REGISTERS-1:0] load_set;
  logic                     accept;
  stage_t                   incoming;
  stage_t                   tail;
  stage_t                   pipe [LATENCY];
  logic [DATA_WIDTH-1:0]    mem  [MEM_DEPTH];
  logic                     unused_bits;

  assign opcode            = instruction_i[OPCODE_LENGTH-1:0];
  assign src_sel           = instruction_i[8 +: REG_SEL_W];
  assign dst_sel           = instruction_i[16 +: REG_SEL_W];
  assign register_select_o = {dst_sel, src_sel};
  assign unused_bits       = ^{instruction_i, register_data_i};

  // A register being written back this cycle is already free: its reader may issue now.
  always_comb begin
    wb_clear = '0;
    if (register_write_o) wb_clear[write_register_select_o] = 1'b1;
  end

  assign busy    = pending & ~wb_clear;
  assign ready_o = !instruction_valid_i || !(busy[src_sel] || busy[dst_sel]);
  assign accept  = instruction_valid_i && ready_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    incoming = '0;
    load_set = '0;
    if (accept) begin
      incoming.reg_sel = src_sel;
      incoming.addr    = register_data_i[DATA_WIDTH +: MEM_ADDR_W];
      incoming.data    = register_data_i[DATA_WIDTH-1:0];
      case (opcode)
        OPC_LOAD: begin
          incoming.op       = OP_LOAD;
          load_set[src_sel] = 1'b1;
        end
        OPC_STORE: incoming.op = OP_STORE;
        default:   incoming.op = OP_ILLEGAL;
      endcase
    end
  end

  assign tail = pipe[LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      // NOTE: the scratch memory is cleared by reset, so it must stay a flop array rather than a RAM macro.
      for (int a = 0; a < MEM_DEPTH; a++) mem[a] <= '0;
      pending                 <= '0;
      instruction_done_o      <= 1'b0;
      register_write_o        <= 1'b0;
      error_o                 <= 1'b0;
      write_register_select_o <= '0;
      register_data_o         <= '0;
    end else begin
      pipe[0] <= incoming;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      instruction_done_o <= (tail.op != OP_NONE);
      register_write_o   <= (tail.op == OP_LOAD);
      error_o            <= (tail.op == OP_ILLEGAL);
      if (tail.op == OP_LOAD) begin
        write_register_select_o <= tail.reg_sel;
        register_data_o         <= mem[tail.addr];
      end
      if (tail.op == OP_STORE) mem[tail.addr] <= tail.data;
      // Set wins over a same-edge clear of the same register.
      pending <= busy | load_set;
    end
  end

`ifdef MAU_PERF_COUNTERS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_count_o  <= '0;
      store_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (tail.op == OP_LOAD)                 load_count_o  <= load_count_o + 32'd1;
      if (tail.op == OP_STORE)                store_count_o <= store_count_o + 32'd1;
      if (instruction_valid_i && !ready_o)    stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_access_unit_pipelined.sv
// Self-checking bench for memory_access_unit_pipelined: directed scenarios plus random traffic
// against a transaction-level model (program-order memory image and a queue of expected completions).
module tb_memory_access_unit_pipelined;

  localparam int LATENCY = 4;
  localparam int DW      = 32;
  localparam int IL      = 32;
  localparam int NR      = 4;
  localparam int MD      = 16;
  localparam int RS      = $clog2(NR);
  localparam int MA      = $clog2(MD);

  logic            clk = 1'b0;
  logic            reset_i;
  logic [IL-1:0]   instruction_i;
  logic            instruction_valid_i;
  logic            ready_o;
  logic [2*RS-1:0] register_select_o;
  logic [2*DW-1:0] register_data_i;
  logic [RS-1:0]   write_register_select_o;
  logic [DW-1:0]   register_data_o;
  logic            register_write_o;
  logic            instruction_done_o;
  logic            error_o;
`ifdef MAU_PERF_COUNTERS_EN
  logic [31:0]     load_count_o, store_count_o, stall_count_o;
`endif

  always #5 clk = ~clk;

  memory_access_unit_pipelined #(
    .LATENCY(LATENCY), .DATA_WIDTH(DW), .INSTRUCTION_LENGTH(IL),
    .OPCODE_LENGTH(8), .NUM_REGISTERS(NR), .MEM_DEPTH(MD)
  ) dut (
    .clk_i                   (clk),
    .reset_i                 (reset_i),
    .instruction_i           (instruction_i),
    .instruction_valid_i     (instruction_valid_i),
    .ready_o                 (ready_o),
    .register_select_o       (register_select_o),
    .register_data_i         (register_data_i),
    .write_register_select_o (write_register_select_o),
    .register_data_o         (register_data_o),
    .register_write_o        (register_write_o),
    .instruction_done_o      (instruction_done_o),
    .error_o                 (error_o)
`ifdef MAU_PERF_COUNTERS_EN
    ,
    .load_count_o            (load_count_o),
    .store_count_o           (store_count_o),
    .stall_count_o           (stall_count_o)
`endif
  );

  // Bench-side register file answers the unit's read selects.
  logic [DW-1:0] rf [NR];
  assign register_data_i = {rf[register_select_o[2*RS-1:RS]], rf[register_select_o[RS-1:0]]};

  typedef struct {
    int            done_edge;
    bit            is_load;
    bit            is_illegal;
    int            rsel;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q [$];
  logic [DW-1:0] mem_m [MD];
  int            cur_edge = 0;
  int            n_pass   = 0;
  int            n_checks = 0;
  int            load_m, store_m, stall_m;
  int            last_rejects;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cur_edge);
  endtask

  function automatic logic [IL-1:0] mk(input logic [7:0] op, input logic [7:0] src, input logic [7:0] dst);
    logic [IL-1:0] w;
    w        = '0;
    w[7:0]   = op;
    w[15:8]  = src;
    w[23:16] = dst;
    return w;
  endfunction

  // A register is busy while an accepted LOAD to it has not reached its write-back cycle.
  function automatic bit reg_busy(input int r);
    foreach (q[i]) if (q[i].is_load && q[i].rsel == r && q[i].done_edge > cur_edge) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (q.size() > 0 && q[0].done_edge == cur_edge) begin
      e = q.pop_front();
      check("done", 64'(instruction_done_o), 64'(1));
      check("error", 64'(error_o), 64'(e.is_illegal));
      check("reg_write", 64'(register_write_o), 64'(e.is_load));
      if (e.is_load) begin
        check("wb_select", 64'(write_register_select_o), 64'(e.rsel));
        check("wb_data", 64'(register_data_o), 64'(e.data));
        load_m++;
      end else if (!e.is_illegal) begin
        store_m++;
      end
    end else begin
      check("idle_done", 64'(instruction_done_o), 64'(0));
      check("idle_write", 64'(register_write_o), 64'(0));
      check("idle_error", 64'(error_o), 64'(0));
    end
  endtask

  // Called just after a falling edge: present inputs, check, advance one full clock.
  task automatic cycle(input bit valid, input logic [IL-1:0] instr, output bit acc);
    logic [RS-1:0] src, dst;
    logic [MA-1:0] addr;
    bit            exp_ready;
    exp_t          e;
    instruction_valid_i = valid;
    instruction_i       = instr;
    #1;
    check_outputs();
    src       = instr[8 +: RS];
    dst       = instr[16 +: RS];
    exp_ready = !valid || !(reg_busy(int'(src)) || reg_busy(int'(dst)));
    check("ready", 64'(ready_o), 64'(exp_ready));
    check("reg_select", 64'(register_select_o), 64'({dst, src}));
    acc = valid && exp_ready;
    if (valid && !exp_ready) stall_m++;
    if (acc) begin
      addr         = rf[dst][MA-1:0];
      e.done_edge  = cur_edge + 1 + LATENCY;
      e.rsel       = int'(src);
      e.is_load    = 1'b0;
      e.is_illegal = 1'b0;
      e.data       = '0;
      case (instr[7:0])
        8'h01:   begin e.is_load = 1'b1; e.data = mem_m[addr]; end
        8'h02:   mem_m[addr] = rf[src];
        default: e.is_illegal = 1'b1;
      endcase
      q.push_back(e);
    end
    @(posedge clk);
    cur_edge++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [IL-1:0] instr);
    bit acc;
    int tries;
    tries = 0;
    do begin
      cycle(1'b1, instr, acc);
      tries++;
    end while (!acc && tries < 4 * LATENCY + 8);
    if (!acc) check("issue_timeout", 64'(0), 64'(1));
    last_rejects = tries - 1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cycle(1'b0, IL'($urandom), acc);
  endtask

  task automatic do_reset();
    reset_i             = 1'b1;
    instruction_valid_i = 1'b1;
    instruction_i       = mk(8'h01, 8'd0, 8'd1);
    q.delete();
    foreach (mem_m[a]) mem_m[a] = '0;
    load_m  = 0;
    store_m = 0;
    stall_m = 0;
    @(posedge clk);
    cur_edge++;
    @(negedge clk);
    #1;
    check("rst_done", 64'(instruction_done_o), 64'(0));
    check("rst_write", 64'(register_write_o), 64'(0));
    check("rst_error", 64'(error_o), 64'(0));
    check("rst_wb_select", 64'(write_register_select_o), 64'(0));
    check("rst_wb_data", 64'(register_data_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));
    @(posedge clk);
    cur_edge++;
    @(negedge clk);
    reset_i             = 1'b0;
    instruction_valid_i = 1'b0;
  endtask

  task automatic load_all_addresses();
    for (int a = 0; a < MD; a++) begin
      rf[1] = DW'(a) | (DW'($urandom) << MA);
      issue(mk(8'h01, 8'(2 * (a % 2)), 8'd1));
    end
  endtask

  initial begin
    bit acc;
    reset_i             = 1'b1;
    instruction_valid_i = 1'b0;
    instruction_i       = '0;
    foreach (rf[r]) rf[r] = $urandom;
    @(negedge clk);
    do_reset();

    // Post-reset load of an address reads zero.
    rf[2] = 32'd9;
    issue(mk(8'h01, 8'd3, 8'd2));
    idle(LATENCY + 1);

    // STORE then back-to-back LOAD of the same address.
    rf[1] = 32'hDEADBEEF;
    rf[2] = 32'd5;
    issue(mk(8'h02, 8'd1, 8'd2));
    issue(mk(8'h01, 8'd3, 8'd2));
    idle(LATENCY + 2);

    // LOAD r0 followed by a STORE sourcing r0 stalls for LATENCY cycles.
    rf[2] = 32'd7;
    issue(mk(8'h01, 8'd0, 8'd2));
    rf[1] = 32'd8;
    issue(mk(8'h02, 8'd0, 8'd1));
    check("raw_stall_cycles", 64'(last_rejects), 64'(LATENCY));
    idle(LATENCY + 2);

    // Address wrap: 0x13 and 0x03 hit the same word.
    rf[1] = 32'h1234_5678;
    rf[2] = 32'h13;
    issue(mk(8'h02, 8'd1, 8'd2));
    rf[3] = 32'h03;
    issue(mk(8'h01, 8'd0, 8'd3));
    idle(LATENCY + 2);

    // Illegal opcode: error pulse, memory at that address untouched.
    rf[1] = 32'hBAD0_BAD0;
    rf[2] = 32'h03;
    issue(mk(8'h7F, 8'd1, 8'd2));
    issue(mk(8'h01, 8'd0, 8'd2));
    idle(LATENCY + 2);

    // Three STOREs in flight are dropped by reset.
    for (int i = 0; i < 3; i++) begin
      rf[1] = 32'hA5A5_0000 + DW'(i + 1);
      rf[2] = DW'(i + 4);
      issue(mk(8'h02, 8'd1, 8'd2));
    end
    do_reset();
    idle(LATENCY + 2);
    load_all_addresses();
    idle(LATENCY + 2);

    // Random traffic, including garbage in the upper bits of the register fields.
    for (int n = 0; n < 400; n++) begin
      logic [7:0]    op;
      logic [IL-1:0] instr;
      int            pick;
      rf[$urandom_range(0, NR - 1)] = $urandom;
      pick = $urandom_range(0, 7);
      if (pick < 3)      op = 8'h01;
      else if (pick < 6) op = 8'h02;
      else               op = 8'($urandom);
      instr = mk(op, 8'($urandom), 8'($urandom));
      instr[IL-1:24] = (IL - 24)'($urandom);
      cycle($urandom_range(0, 3) != 0, instr, acc);
    end
    idle(LATENCY + 2);

`ifdef MAU_PERF_COUNTERS_EN
    check("load_count", 64'(load_count_o), 64'(load_m));
    check("store_count", 64'(store_count_o), 64'(store_m));
    check("stall_count", 64'(stall_count_o), 64'(stall_m));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
